// File: rtl/dmem_pkg.sv
// Shared types and constants for the data_memory block.
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2,
        WIDTH_RSVD = 2'd3
    } dmem_width_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/data_memory_if.sv
// CPU load/store port of data_memory, plus the FSM state exported for observation.
interface data_memory_if;
    import dmem_pkg::*;

    // Handshake: the initiator raises read_enable or write_enable with address,
    // write_data and write_wstrb stable, and holds them until mem_valid is seen.
    // mem_valid is a one-cycle strobe; the level during that cycle is ignored
    // and the initiator may drop or replace the request from the next edge on.
    logic [31:0] address;
    logic        read_enable;
    logic        write_enable;
    logic [31:0] write_data;
    logic [1:0]  write_wstrb;
    logic [31:0] read_data;
    logic        mem_valid;
    logic        busy;
    logic        access_error;
    dmem_state_e state;

    modport master (
        output address, read_enable, write_enable, write_data, write_wstrb,
        input  read_data, mem_valid, busy, access_error, state
    );

    modport slave (
        input  address, read_enable, write_enable, write_data, write_wstrb,
        output read_data, mem_valid, busy, access_error, state
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte/half/word lane steering between a right-aligned CPU value and a stored word.
// DMEM_MISALIGN_ERR_EN: flag misaligned halves/words instead of forcing alignment.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  dmem_width_e width_i,
    input  logic [31:0] write_data_i,
    input  logic [31:0] stored_word_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] write_word_o,
    output logic [31:0] read_value_o,
    output logic        misaligned_o
);

    logic [1:0] eff_off;

    always_comb begin
`ifdef DMEM_MISALIGN_ERR_EN
        eff_off      = offset_i;
        misaligned_o = ((width_i == WIDTH_HALF) && offset_i[0]) ||
                       ((width_i == WIDTH_WORD) && (offset_i != 2'b00));
`else
        misaligned_o = 1'b0;
        case (width_i)
            WIDTH_HALF: eff_off = offset_i & 2'b10;
            WIDTH_WORD: eff_off = 2'b00;
            default:    eff_off = offset_i;
        endcase
`endif
    end

    // Write data is replicated across lanes; byte_en picks the lanes that land.
    always_comb begin
        byte_en_o    = 4'b0000;
        write_word_o = 32'h0;
        read_value_o = 32'h0;
        case (width_i)
            WIDTH_BYTE: begin
                byte_en_o    = 4'b0001 << eff_off;
                write_word_o = {4{write_data_i[7:0]}};
                read_value_o = {24'h0, stored_word_i[{eff_off, 3'b000} +: 8]};
            end
            WIDTH_HALF: begin
                byte_en_o    = 4'b0011 << {eff_off[1], 1'b0};
                write_word_o = {2{write_data_i[15:0]}};
                read_value_o = {16'h0, stored_word_i[{eff_off[1], 4'b0000} +: 16]};
            end
            WIDTH_WORD: begin
                byte_en_o    = 4'b1111;
                write_word_o = write_data_i;
                read_value_o = stored_word_i;
            end
            default: begin
                byte_en_o    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM on the CPU load/store port with programmable wait states.
// Misalignment rejection is controlled by DMEM_MISALIGN_ERR_EN (see dmem_lane_align).
module data_memory
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 1
) (
    input  logic          clock,
    input  logic          reset,
    data_memory_if.slave  bus
);

    localparam int             IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0]    SPAN   = 33'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             access_error_q, access_error_d;

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [32:0]      rel_addr;
    logic             in_range;
    logic [IDX_W-1:0] index;
    dmem_width_e      width;
    logic [31:0]      stored_word;
    logic [3:0]       byte_en;
    logic [31:0]      write_word;
    logic [31:0]      read_value;
    logic             misaligned;
    logic             req_error;
    logic             mem_we;

    // A borrow out of the subtraction lands in bit 32, so one compare covers both bounds.
    assign rel_addr    = {1'b0, bus.address} - {1'b0, BASE_ADDR};
    assign in_range    = rel_addr < SPAN;
    assign index       = rel_addr[IDX_W+1:2];
    assign width       = dmem_width_e'(bus.write_wstrb);
    assign stored_word = mem_q[index];
    assign req_error   = !in_range || (width == WIDTH_RSVD) || misaligned;

    dmem_lane_align u_lane_align (
        .offset_i      (bus.address[1:0]),
        .width_i       (width),
        .write_data_i  (bus.write_data),
        .stored_word_i (stored_word),
        .byte_en_o     (byte_en),
        .write_word_o  (write_word),
        .read_value_o  (read_value),
        .misaligned_o  (misaligned)
    );

    // All data movement happens at the accept edge; WAIT/RESP only pace the response.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        read_data_d    = read_data_q;
        access_error_d = access_error_q;
        mem_we         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.read_enable || bus.write_enable) begin
                    access_error_d = req_error;
                    read_data_d    = (!bus.write_enable && !req_error) ? read_value : 32'h0;
                    mem_we         = bus.write_enable && !req_error;
                    count_d        = LAT_M1;
                    state_d        = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            read_data_q    <= 32'h0;
            access_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            read_data_q    <= read_data_d;
            access_error_q <= access_error_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[index][8*b +: 8] <= write_word[8*b +: 8];
                end
            end
        end
    end

    assign bus.read_data    = read_data_q;
    assign bus.mem_valid    = (state_q == RESP);
    assign bus.busy         = (state_q != IDLE);
    assign bus.access_error = access_error_q;
    assign bus.state        = state_q;

endmodule
